// File: rtl/game_pkg.sv
// Shared codes for the battle screen: keys, pages, player opcodes, directions.
// Also holds the helper that packs {page, substage} into the state byte.
package game_pkg;

  localparam logic [3:0] KEY_NONE  = 4'd0;
  localparam logic [3:0] KEY_W     = 4'd1;
  localparam logic [3:0] KEY_D     = 4'd2;
  localparam logic [3:0] KEY_S     = 4'd3;
  localparam logic [3:0] KEY_A     = 4'd4;
  localparam logic [3:0] KEY_SPACE = 4'd5;

  typedef enum logic [3:0] {
    PG_MENU   = 4'd1,
    PG_DODGE  = 4'd9,
    PG_ATTACK = 4'd10,
    PG_ACTION = 4'd11
  } page_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_HPY  = 4'd1,
    OP_DPY  = 4'd2,
    OP_IDG  = 4'd3,
    OP_SDG  = 4'd4,
    OP_MOV  = 4'd5,
    OP_SHP  = 4'd6
  } opcode_e;

  typedef enum logic [7:0] {
    DIR_UP    = 8'd0,
    DIR_LEFT  = 8'd1,
    DIR_DOWN  = 8'd2,
    DIR_RIGHT = 8'd3
  } dir_e;

  function automatic logic [7:0] pack_state(input logic [3:0] page, input logic [3:0] sub);
    return {page, sub};
  endfunction

endpackage

// File: rtl/battle_controller_if.sv
// Battle controller bus: keyboard/engine inputs and state/HP/event outputs.
// master = controller side, slave = keyboard decoder / engine / renderer side.
interface battle_controller_if #(parameter int HP_W = 8);
  logic [3:0]      keyboard;
  logic            is_death;
  logic            atk_pass;
  logic [HP_W-1:0] dmg_mon;
  logic [7:0]      state;
  logic [15:0]     player_instruction;
  logic            is_move;
  logic [HP_W-1:0] mon_hp;
  logic            win;
  logic            lose;

  modport master (
    input  keyboard, is_death, atk_pass, dmg_mon,
    output state, player_instruction, is_move, mon_hp, win, lose
  );

  modport slave (
    output keyboard, is_death, atk_pass, dmg_mon,
    input  state, player_instruction, is_move, mon_hp, win, lose
  );
endinterface

// File: rtl/battle_controller_key_edge.sv
// Registers the key code and flags a one-cycle event when a new nonzero key appears.
// Latency 1 cycle from keyboard to key_evt; no backpressure.
module key_edge
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] keyboard,
  output logic       key_evt,
  output logic [3:0] key_code
);

  logic [3:0] key_q;
  logic [3:0] key_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= KEY_NONE;
      key_prev <= KEY_NONE;
    end else begin
      key_q    <= keyboard;
      key_prev <= key_q;
    end
  end

  assign key_evt  = (key_q != key_prev) && (key_q != KEY_NONE);
  assign key_code = key_q;

endmodule

// File: rtl/battle_controller.sv
// Battle screen sequencer: MENU -> DODGE (timed) -> ACTION menu -> ATTACK, with HP and win/lose.
// All outputs registered, one cycle after the qualifying event; no backpressure.
module battle_controller
  import game_pkg::*;
#(
  parameter int HP_W         = 8,
  parameter int MON_HP_MAX   = 100,
  parameter int DODGE_CYCLES = 1000,
  parameter int N_ACTIONS    = 4,
  parameter int CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  battle_controller_if.master bus
);

  localparam logic [CNT_W-1:0] TMR_RELOAD = CNT_W'(DODGE_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX   = 4'(N_ACTIONS - 1);
  localparam logic [HP_W:0]    HP_SAT     = {1'b0, {HP_W{1'b1}}};
  localparam logic [HP_W:0]    KILL_HP    = (HP_W+1)'(MON_HP_MAX);

  page_e           page_q, page_d;
  logic [3:0]      sub_q, sub_d;
  logic [15:0]     pi_q, pi_d;
  logic            move_q, move_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  logic       key_evt;
  logic [3:0] key_code;
  logic       mv_vld;
  dir_e       mv_dir;
  logic [HP_W:0] sum_raw, sum_sat;

  key_edge u_key_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .keyboard (bus.keyboard),
    .key_evt  (key_evt),
    .key_code (key_code)
  );

  // Movement follows the held key level, not its edge.
  always_comb begin
    mv_vld = 1'b1;
    mv_dir = DIR_UP;
    case (key_code)
      KEY_W:   mv_dir = DIR_UP;
      KEY_A:   mv_dir = DIR_LEFT;
      KEY_S:   mv_dir = DIR_DOWN;
      KEY_D:   mv_dir = DIR_RIGHT;
      default: mv_vld = 1'b0;
    endcase
  end

  assign sum_raw = {1'b0, hp_q} + {1'b0, bus.dmg_mon};
  assign sum_sat = (sum_raw > HP_SAT) ? HP_SAT : sum_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q  <= PG_MENU;
      sub_q   <= 4'd0;
      pi_q    <= 16'd0;
      move_q  <= 1'b0;
      hp_q    <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      page_q  <= page_d;
      sub_q   <= sub_d;
      pi_q    <= pi_d;
      move_q  <= move_d;
      hp_q    <= hp_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    page_d  = page_q;
    sub_d   = sub_q;
    pi_d    = pi_q;
    move_d  = 1'b0;
    hp_d    = hp_q;
    win_d   = 1'b0;
    lose_d  = 1'b0;
    timer_d = timer_q;
    case (page_q)
      PG_MENU: begin
        if (key_evt && key_code == KEY_SPACE) begin
          page_d  = PG_DODGE;
          sub_d   = 4'd0;
          hp_d    = '0;
          timer_d = TMR_RELOAD;
        end
      end
      PG_DODGE: begin
        // Death outranks both timer expiry and movement.
        if (bus.is_death) begin
          page_d = PG_MENU;
          sub_d  = 4'd0;
          lose_d = 1'b1;
        end else if (timer_q == '0) begin
          page_d = PG_ACTION;
          sub_d  = 4'd0;
        end else begin
          timer_d = timer_q - 1'b1;
          if (mv_vld) begin
            move_d = 1'b1;
            pi_d   = {OP_MOV, mv_dir, 4'b0000};
          end
        end
      end
      PG_ACTION: begin
        if (key_evt) begin
          case (key_code)
            KEY_W: sub_d = (sub_q == 4'd0) ? LAST_IDX : sub_q - 4'd1;
            KEY_S: sub_d = (sub_q == LAST_IDX) ? 4'd0 : sub_q + 4'd1;
            KEY_SPACE: begin
              sub_d = 4'd0;
              if (sub_q == 4'd0) begin
                page_d = PG_ATTACK;
              end else begin
                page_d  = PG_DODGE;
                timer_d = TMR_RELOAD;
              end
            end
            default: ;
          endcase
        end
      end
      PG_ATTACK: begin
        if (bus.atk_pass) begin
          hp_d  = sum_sat[HP_W-1:0];
          sub_d = 4'd0;
          if (sum_sat >= KILL_HP) begin
            page_d = PG_MENU;
            win_d  = 1'b1;
          end else begin
            page_d  = PG_DODGE;
            timer_d = TMR_RELOAD;
          end
        end
      end
      default: begin
        page_d = PG_MENU;
        sub_d  = 4'd0;
      end
    endcase
  end

  assign bus.state              = pack_state(page_q, sub_q);
  assign bus.player_instruction = pi_q;
  assign bus.is_move            = move_q;
  assign bus.mon_hp             = hp_q;
  assign bus.win                = win_q;
  assign bus.lose               = lose_q;

endmodule

// File: tb/tb_battle_controller.sv
// Directed bench for battle_controller with DODGE_CYCLES=8, N_ACTIONS=4, HP_W=8.
// Expected values are hand-computed constants.
module tb_battle_controller;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  battle_controller_if #(.HP_W(8)) bif ();

  battle_controller #(
    .HP_W         (8),
    .MON_HP_MAX   (100),
    .DODGE_CYCLES (8),
    .N_ACTIONS    (4),
    .CNT_W        (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    bif.keyboard = k;
    tick(1);
    bif.keyboard = 4'd0;
    tick(1);
  endtask

  task automatic attack(input logic [7:0] dmg);
    bif.atk_pass = 1'b1;
    bif.dmg_mon  = dmg;
    tick(1);
    bif.atk_pass = 1'b0;
    bif.dmg_mon  = 8'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bif.keyboard = 4'd0;
    bif.is_death = 1'b0;
    bif.atk_pass = 1'b0;
    bif.dmg_mon  = 8'd0;
    #12;
    check_eq("rst_state", bif.state, 32'h10);
    check_eq("rst_pi",    bif.player_instruction, 32'h0);
    check_eq("rst_move",  bif.is_move, 32'h0);
    check_eq("rst_hp",    bif.mon_hp, 32'h0);
    check_eq("rst_win",   bif.win, 32'h0);
    check_eq("rst_lose",  bif.lose, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // SPACE held: one transition, two cycles after the key appears
    bif.keyboard = 4'd5;
    tick(1);
    check_eq("space_lat", bif.state, 32'h10);
    tick(1);
    check_eq("space_dodge", bif.state, 32'h90);
    check_eq("space_hp", bif.mon_hp, 32'h0);
    tick(3);
    check_eq("space_hold", bif.state, 32'h90);

    bif.keyboard = 4'd4;
    tick(2);
    check_eq("mov_a_pi",   bif.player_instruction, 32'h5010);
    check_eq("mov_a_move", bif.is_move, 32'h1);
    bif.keyboard = 4'd0;
    tick(2);
    check_eq("rel_move",  bif.is_move, 32'h0);
    check_eq("rel_pi",    bif.player_instruction, 32'h5010);
    check_eq("dodge_len", bif.state, 32'h90);
    tick(1);
    check_eq("action_in", bif.state, 32'hB0);
    check_eq("action_mv", bif.is_move, 32'h0);

    // Menu navigation with wrap-around
    press(4'd1);
    check_eq("act_w_wrap", bif.state, 32'hB3);
    press(4'd3);
    check_eq("act_s_wrap", bif.state, 32'hB0);
    press(4'd3);
    check_eq("act_s", bif.state, 32'hB1);
    press(4'd5);
    check_eq("act_skip", bif.state, 32'h90);
    tick(7);
    check_eq("skip_reload", bif.state, 32'h90);
    tick(1);
    check_eq("skip_action", bif.state, 32'hB0);

    // FIGHT: two attacks, second one kills
    press(4'd5);
    check_eq("fight", bif.state, 32'hA0);
    bif.is_death = 1'b1;
    tick(2);
    bif.is_death = 1'b0;
    check_eq("atk_hold", bif.state, 32'hA0);
    attack(8'd60);
    check_eq("atk1_hp",    bif.mon_hp, 32'd60);
    check_eq("atk1_state", bif.state, 32'h90);
    check_eq("atk1_win",   bif.win, 32'h0);
    tick(8);
    check_eq("atk1_action", bif.state, 32'hB0);
    press(4'd5);
    attack(8'd50);
    check_eq("atk2_hp",    bif.mon_hp, 32'd110);
    check_eq("atk2_win",   bif.win, 32'h1);
    check_eq("atk2_state", bif.state, 32'h10);
    tick(1);
    check_eq("win_pulse", bif.win, 32'h0);
    check_eq("hp_held",   bif.mon_hp, 32'd110);

    // Death on the same cycle the timer expires
    press(4'd5);
    check_eq("d_enter", bif.state, 32'h90);
    check_eq("d_hp_clr", bif.mon_hp, 32'h0);
    tick(7);
    bif.is_death = 1'b1;
    tick(1);
    bif.is_death = 1'b0;
    check_eq("death_state", bif.state, 32'h10);
    check_eq("death_lose",  bif.lose, 32'h1);
    tick(1);
    check_eq("lose_pulse", bif.lose, 32'h0);
    check_eq("death_stay", bif.state, 32'h10);

    // Saturating HP: 60 + 250 clamps to 255
    press(4'd5);
    tick(8);
    press(4'd5);
    attack(8'd60);
    tick(8);
    press(4'd5);
    check_eq("sat_fight", bif.state, 32'hA0);
    attack(8'd250);
    check_eq("sat_hp",    bif.mon_hp, 32'd255);
    check_eq("sat_win",   bif.win, 32'h1);
    check_eq("sat_state", bif.state, 32'h10);

    // Asynchronous reset in the middle of DODGE
    tick(1);
    press(4'd5);
    bif.keyboard = 4'd2;
    tick(2);
    check_eq("mov_d_pi", bif.player_instruction, 32'h5030);
    rst_n = 1'b0;
    #1;
    check_eq("arst_state", bif.state, 32'h10);
    check_eq("arst_pi",    bif.player_instruction, 32'h0);
    check_eq("arst_move",  bif.is_move, 32'h0);
    bif.keyboard = 4'd0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check_eq("post_rst", bif.state, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
